// File: rtl/color_fsm_driver_pkg.sv
// Shared types for the colour FSM driver: colour states, output codes,
// the no-op command and the controller state encoding.
package color_pkg;

  typedef enum logic [1:0] {
    BLUE     = 2'd0,
    RED      = 2'd1,
    HSV_IDLE = 2'd2
  } color_e;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_DRIVE = 2'd1,
    C_CHECK = 2'd2,
    C_DONE  = 2'd3
  } ctrl_e;

  localparam logic [1:0] CODE_BLUE = 2'h1;
  localparam logic [1:0] CODE_RED  = 2'h2;
  localparam logic [1:0] CODE_HSV  = 2'h2;
  localparam logic [1:0] CMD_NOP   = 2'h3;

  // Next hop toward tgt; Blue<->HSV_idle always routes through Red.
  function automatic logic [1:0] path_cmd(input logic [1:0] cur, input logic [1:0] tgt);
    case (cur)
      BLUE:     path_cmd = 2'h1;
      RED:      path_cmd = (tgt == BLUE) ? 2'h1 : 2'h2;
      HSV_IDLE: path_cmd = 2'h0;
      default:  path_cmd = CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/color_fsm_driver_if.sv
// Request / command / observation bundle between a requester, the driver
// and the colour FSM it steers.
interface color_fsm_driver_if;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready;
  logic [1:0] cmd;
  logic [1:0] obs_code;
  logic [1:0] shadow_state;
  logic       done;
  logic       error;

  modport master (
    output req_valid, req_target, obs_code,
    input  req_ready, cmd, shadow_state, done, error
  );

  modport slave (
    input  req_valid, req_target, obs_code,
    output req_ready, cmd, shadow_state, done, error
  );
endinterface

// File: rtl/color_fsm_driver_model.sv
// Combinational copy of the colour FSM: next state and expected output
// code for a given state and command.
module color_fsm_model
  import color_pkg::*;
(
  input  logic [1:0] state,
  input  logic [1:0] cmd,
  output logic [1:0] next_state,
  output logic [1:0] exp_code
);

  always_comb begin
    next_state = state;
    case (state)
      BLUE:     if (cmd == 2'h1) next_state = RED;
      RED: begin
        case (cmd)
          2'h0:    next_state = RED;
          2'h1:    next_state = BLUE;
          2'h2:    next_state = HSV_IDLE;
          default: next_state = RED;
        endcase
      end
      HSV_IDLE: if (cmd == 2'h0) next_state = RED;
      default:  next_state = state;
    endcase
  end

  always_comb begin
    case (state)
      BLUE:    exp_code = CODE_BLUE;
      RED:     exp_code = CODE_RED;
      default: exp_code = CODE_HSV;
    endcase
  end

endmodule

// File: rtl/color_fsm_driver.sv
// Steers an external colour FSM to a requested state one hop at a time,
// tracking it with a shadow copy. COLOR_DRV_CHECK_EN enables obs_code checking.
module color_fsm_driver
  import color_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  color_fsm_driver_if.slave  bus
);

  ctrl_e      state;
  logic [1:0] shadow;
  logic [1:0] target;
  logic [1:0] nxt_color;
  logic [1:0] exp_code;
  logic       mismatch;
  logic       accept;

  assign accept           = (state == C_IDLE) && bus.req_valid;
  assign bus.req_ready    = (state == C_IDLE);
  assign bus.done         = (state == C_DONE);
  assign bus.cmd          = (state == C_DRIVE) ? path_cmd(shadow, target) : CMD_NOP;
  assign bus.shadow_state = shadow;

  color_fsm_model u_model (
    .state      (shadow),
    .cmd        (bus.cmd),
    .next_state (nxt_color),
    .exp_code   (exp_code)
  );

`ifdef COLOR_DRV_CHECK_EN
  logic err;
  assign mismatch  = (bus.obs_code != exp_code);
  assign bus.error = err;

  always_ff @(posedge clk) begin
    if (rst)                                err <= 1'b0;
    else if (accept)                        err <= 1'b0;
    else if (state == C_CHECK && mismatch)  err <= 1'b1;
  end
`else
  logic unused_obs;
  assign unused_obs = ^{bus.obs_code, exp_code};
  assign mismatch   = 1'b0;
  assign bus.error  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= C_IDLE;
      shadow <= RED;
      target <= RED;
    end else begin
      case (state)
        C_IDLE: if (accept) begin
          target <= bus.req_target;
          state  <= (bus.req_target == shadow || bus.req_target == 2'h3) ? C_DONE : C_DRIVE;
        end
        C_DRIVE: begin
          shadow <= nxt_color;
          state  <= C_CHECK;
        end
        C_CHECK: begin
          if (mismatch || shadow == target) state <= C_DONE;
          else                              state <= C_DRIVE;
        end
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_fsm_driver.sv
// Directed + random bench for color_fsm_driver wired to a behavioural colour FSM.
module tb_color_fsm_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  color_fsm_driver_if bus ();

  color_fsm_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  target;
    int          lat;
    logic [15:0] seq;
    logic [1:0]  shadow;
  } vec_t;

  vec_t       vecs [9];
  logic [1:0] fsm;
  logic       force_en;
  logic [1:0] force_val;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic [1:0] c);
    case (s)
      2'd0:    return (c == 2'd1) ? 2'd1 : 2'd0;
      2'd1:    return (c == 2'd0) ? 2'd1 : (c == 2'd1) ? 2'd0 : (c == 2'd2) ? 2'd2 : 2'd1;
      2'd2:    return (c == 2'd0) ? 2'd1 : 2'd2;
      default: return s;
    endcase
  endfunction

  // Reference colour FSM the driver is steering.
  always @(posedge clk) begin
    if (rst) fsm <= 2'd1;
    else     fsm <= fsm_next(fsm, bus.cmd);
  end

  always_comb bus.obs_code = force_en ? force_val : ((fsm == 2'd0) ? 2'h1 : 2'h2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, keep junk on the request lines while busy, and
  // return the accept-to-done latency and the cmd history before done.
  task automatic run_req(input logic [1:0] t, output int lat, output logic [15:0] seq);
    lat = 0;
    seq = '0;
    @(negedge clk);
    chk("ready_idle", bus.req_ready, 1);
    chk("done_idle", bus.done, 0);
    bus.req_valid  = 1'b1;
    bus.req_target = t;
    @(posedge clk);
    #1 bus.req_target = 2'($urandom_range(0, 3));
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("ready_busy", bus.req_ready, 0);
      if (bus.done) begin
        lat = c;
        break;
      end
      seq = {seq[13:0], bus.cmd};
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] seq;
    logic [1:0]  exp_sh;
    logic [1:0]  t;
    int          steps;

    vecs[0] = '{2'd0, 3, 16'h0007, 2'd0};
    vecs[1] = '{2'd2, 5, 16'h007B, 2'd2};
    vecs[2] = '{2'd2, 1, 16'h0000, 2'd2};
    vecs[3] = '{2'd3, 1, 16'h0000, 2'd2};
    vecs[4] = '{2'd0, 5, 16'h0037, 2'd0};
    vecs[5] = '{2'd1, 3, 16'h0007, 2'd1};
    vecs[6] = '{2'd2, 3, 16'h000B, 2'd2};
    vecs[7] = '{2'd1, 3, 16'h0003, 2'd1};
    vecs[8] = '{2'd1, 1, 16'h0000, 2'd1};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_target = 2'd0;
    force_en = 1'b0;
    force_val = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_cmd", bus.cmd, 2'h3);
    chk("rst_shadow", bus.shadow_state, 2'd1);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].target, lat, seq);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_seq", i), seq, vecs[i].seq);
      chk($sformatf("v%0d_shadow", i), bus.shadow_state, vecs[i].shadow);
      chk($sformatf("v%0d_error", i), bus.error, 0);
      chk($sformatf("v%0d_track", i), bus.shadow_state, fsm);
    end

    // Reset during the DRIVE cycle of Red->HSV_idle.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_target = 2'd2;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rd_drive_cmd", bus.cmd, 2'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rd_ready", bus.req_ready, 1);
    chk("rd_shadow", bus.shadow_state, 2'd1);
    chk("rd_cmd", bus.cmd, 2'h3);
    chk("rd_done", bus.done, 0);
    chk("rd_error", bus.error, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rd_stay_idle", bus.req_ready, 1);
      chk("rd_stay_cmd", bus.cmd, 2'h3);
    end

    // Reset during CHECK of Red->Blue: shadow already moved, must return to Red.
    bus.req_valid = 1'b1;
    bus.req_target = 2'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rc_check_shadow", bus.shadow_state, 2'd0);
    chk("rc_check_cmd", bus.cmd, 2'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rc_ready", bus.req_ready, 1);
    chk("rc_shadow", bus.shadow_state, 2'd1);
    chk("rc_done", bus.done, 0);

`ifdef COLOR_DRV_CHECK_EN
    force_en = 1'b1;
    force_val = 2'h2;
    run_req(2'd0, lat, seq);
    chk("err_lat", lat, 3);
    chk("err_flag", bus.error, 1);
    chk("err_shadow", bus.shadow_state, 2'd0);
    force_en = 1'b0;
    run_req(2'd0, lat, seq);
    chk("err_clear", bus.error, 0);
    chk("err_clear_lat", lat, 1);
    exp_sh = 2'd0;
`else
    run_req(2'd0, lat, seq);
    chk("nochk_pre_shadow", bus.shadow_state, 2'd0);
    force_en = 1'b1;
    force_val = 2'h0;
    run_req(2'd2, lat, seq);
    chk("nochk_lat", lat, 5);
    chk("nochk_error", bus.error, 0);
    chk("nochk_shadow", bus.shadow_state, 2'd2);
    force_en = 1'b0;
    exp_sh = 2'd2;
`endif

    for (int i = 0; i < 20; i++) begin
      t = 2'($urandom_range(0, 3));
      if (t == 2'd3 || t == exp_sh)           steps = 0;
      else if (t == 2'd1 || exp_sh == 2'd1)   steps = 1;
      else                                    steps = 2;
      run_req(t, lat, seq);
      if (t != 2'd3) exp_sh = t;
      chk($sformatf("r%0d_lat", i), lat, 1 + 2 * steps);
      chk($sformatf("r%0d_shadow", i), bus.shadow_state, exp_sh);
      chk($sformatf("r%0d_track", i), bus.shadow_state, fsm);
      chk($sformatf("r%0d_error", i), bus.error, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
